eth_frame_loop_rx_wide: RTL and testbench
=========================================

// Module: eth_frame_loop_rx_wide
// PURPOSE
//  Multi-byte successor of the loop RX stage. Sits between the MAC RX stream and the loop frame and status FIFOs.
//  - Input has no back-pressure. Frames pass through with zero latency.
//  - Computes a per-frame ones-complement checksum, byte length and flags, and writes them as one status word.
//  - Frames that start while the sinks are not ready are dropped whole.
//  - Frames whose sink stalls mid-frame are truncated with an error beat.
// PARAMETERS
//  C_AXIS_BYTES   4   bytes per beat (1,2,4,8); tdata = 8*C_AXIS_BYTES bits
//  C_CSUM_START  14   byte offset where checksum accumulation starts (0..65535)
// PORTS
//  clk                   in   1      clock
//  rst_n                 in   1      synchronous, active-low reset
//  mode                  in   1      0: status at frame start; 1: status at frame end; sampled at frame start
//  m_axis_frame_tdata    out  8*B    frame data
//  m_axis_frame_tkeep    out  B      byte enables, contiguous from bit 0
//  m_axis_frame_tuser    out  1      frame error
//  m_axis_frame_tlast    out  1      last beat
//  m_axis_frame_tvalid   out  1      beat valid
//  m_axis_frame_tready   in   1      sink ready
//  m_axis_status_tdata   out  40     {csum[15:0], len[15:0], flags[7:0]}
//  m_axis_status_tvalid  out  1      status valid
//  m_axis_status_tready  in   1      status sink ready
//  s_axis_tdata          in   8*B    MAC data
//  s_axis_tkeep          in   B      byte enables; only the tlast beat may be partial
//  s_axis_tuser          in   2      [0] rx error, [1] frame modified
//  s_axis_tlast          in   1      last beat
//  s_axis_tvalid         in   1      beat valid (no tready: source never stalls)
//  drop_count            out  32     frames dropped whole or truncated
//  frame_count           out  32     frames completed without truncation
// BEHAVIOUR
//  Reset: state=IDLE; all tvalid=0, tdata=0, tkeep=0, tuser=0, tlast=0; counters=0; status holding register empty.
//  - Reset mid-frame: remaining beats of that frame are discarded (DISCARD entered after reset until tlast).
//  States: IDLE, PASS, TRUNC, DISCARD.
//  IDLE, on a valid beat:
//  - If frame_tready & status_tready & holding register empty: pass the beat, latch mode, go to PASS.
//    - Mode 0: write status now {0, 0, flags}.
//    - Exception: a 1-beat frame (tlast) stays in IDLE.
//  - Otherwise: drop the beat, drop_count++, go to DISCARD (stay in IDLE if tlast).
//  PASS: frame outputs = inputs combinationally.
//  - frame_tready low while s_axis_tvalid=1 -> beat lost; go to TRUNC.
//  - tlast accepted -> back to IDLE.
//    - Mode 1: load the holding register; status_tvalid rises the next cycle and holds until accepted.
//  TRUNC:
//  - Mode 1: write status first, with flags[1]=1, csum=0, len=bytes so far.
//  - Then emit one beat {tdata=0, tkeep=1, tuser=1, tlast=1}, held until frame_tready.
//  - drop_count++.
//  - Next state: DISCARD, or IDLE if the lost beat or any beat seen during TRUNC had tlast.
//  DISCARD: ignore input; on tlast go to IDLE.
//  Flags:
//  - [0] OR of s_axis_tuser[1] over the frame (mode 0: first beat only).
//  - [1] truncated.
//  - [2] OR of s_axis_tuser[0].
//  - [3] latched mode.
//  - [7:4] 0.
//  Length: sum of popcount(tkeep), saturating at 16'hFFFF.
//  Checksum:
//  - 16-bit ones-complement sum, not inverted, of bytes at absolute offset >= C_CSUM_START.
//  - Byte pairing: even offset = high byte; an odd trailing byte is padded with low 8'h00.
//  - Carries folded end-around each beat; a result of 16'h0000 is reported as 16'hFFFF only if the sum was nonzero.
//  frame_count++ on a non-truncated tlast.
//  - If drop_count and frame_count both increment in the same cycle, both update.
//  - Counters wrap at 2^32.
// CONFIGURATION
//  ETH_FRAME_LOOP_RX_STATS_EN:
//  - Defined: drop_count and frame_count are live as above.
//  - Undefined: both are tied to 32'd0 and the counter logic is removed; all other behaviour is identical.
// TESTING
//  - B=4, mode=1, 64B frame of bytes 0x00..0x3F, sinks ready -> 16 beats passed unchanged; one status len=64, flags=0x08, csum = reference model value.
//  - B=4, 61B frame -> last beat tkeep=4'b0001; len=61; odd byte padded low in csum.
//  - frame_tready dropped at beat 5 of 16 -> status flags[1]=1, len=16; one tuser=1/tlast beat; beats 6-16 discarded; drop_count=1.
//  - status_tready=0 when a frame starts -> no frame beats out; drop_count=1; the next frame after ready passes normally.
//  - mode=0, first beat tuser[1]=1 -> status written in the first-beat cycle: {0, 0, 8'h01}.
//  - Reset asserted mid-frame, then released -> no output until the next frame start; counters read 0.

Source files
------------

// File: rtl/eth_frame_loop_rx_wide.sv
// eth_frame_loop_rx_wide: multi-byte loop RX stage between the MAC RX stream and
// the loop frame/status FIFOs. Frames pass with zero latency while a status word
// {csum[15:0], len[15:0], flags[7:0]} is built per frame. Frames that start while
// the sinks are busy are dropped whole; a mid-frame sink stall truncates the frame
// with an error beat.
// Optional feature: define ETH_FRAME_LOOP_RX_STATS_EN for live drop/frame counters.
module eth_frame_loop_rx_wide #(
    parameter int unsigned C_AXIS_BYTES = 4,
    parameter int unsigned C_CSUM_START = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    output logic [8*C_AXIS_BYTES-1:0] m_axis_frame_tdata,
    output logic [C_AXIS_BYTES-1:0]   m_axis_frame_tkeep,
    output logic                      m_axis_frame_tuser,
    output logic                      m_axis_frame_tlast,
    output logic                      m_axis_frame_tvalid,
    input  logic                      m_axis_frame_tready,
    output logic [39:0]               m_axis_status_tdata,
    output logic                      m_axis_status_tvalid,
    input  logic                      m_axis_status_tready,
    input  logic [8*C_AXIS_BYTES-1:0] s_axis_tdata,
    input  logic [C_AXIS_BYTES-1:0]   s_axis_tkeep,
    input  logic [1:0]                s_axis_tuser,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic [31:0]               drop_count,
    output logic [31:0]               frame_count
);

    typedef enum logic [1:0] {IDLE, PASS, TRUNC, DISCARD} state_t;
    state_t state, state_next;

    // Frame accumulators and latched per-frame context
    logic        mid_frame;
    logic        mode_q;
    logic [31:0] off;
    logic [15:0] csum;
    logic        csum_nz, mod_q, err_q, seen_last;
    logic        hold_valid;
    logic [39:0] hold_data;

    // Per-beat combinational results
    logic        first, cur_mode;
    logic [7:0]  byte_val;
    logic [31:0] base_off, beat_sum, beat_len, fold1, off_new;
    logic [16:0] fold2;
    logic [15:0] csum_new, csum_fin, len_new, len_cur;
    logic        beat_nz, nz_new, mod_new, err_new;

    // Control strobes
    logic take, start_write, load_end, load_trunc, drop_inc, frame_inc;

    // Running length/checksum/flag values including the current input beat
    always_comb begin
        first    = (state == IDLE);
        cur_mode = first ? mode : mode_q;
        base_off = first ? '0 : off;
        beat_sum = '0;
        beat_len = '0;
        beat_nz  = 1'b0;
        byte_val = '0;
        for (int unsigned i = 0; i < C_AXIS_BYTES; i++) begin
            byte_val = s_axis_tdata[8*i +: 8];
            if (s_axis_tkeep[i]) begin
                beat_len = beat_len + 32'd1;
                if (base_off + i >= C_CSUM_START) begin
                    beat_nz = beat_nz | (byte_val != 8'h00);
                    // even absolute offset carries the high byte of a 16-bit word
                    if (base_off[0] == i[0])
                        beat_sum = beat_sum + {16'h0, byte_val, 8'h00};
                    else
                        beat_sum = beat_sum + {24'h0, byte_val};
                end
            end
        end
        fold1    = {16'h0, (first ? 16'h0 : csum)} + beat_sum;
        fold2    = {1'b0, fold1[15:0]} + {1'b0, fold1[31:16]};
        csum_new = fold2[15:0] + {15'h0, fold2[16]};
        off_new  = base_off + beat_len;
        nz_new   = (!first && csum_nz) || beat_nz;
        mod_new  = (!first && mod_q) || s_axis_tuser[1];
        err_new  = (!first && err_q) || s_axis_tuser[0];
        len_new  = (off_new[31:16] != 16'h0) ? 16'hFFFF : off_new[15:0];
        len_cur  = (off[31:16] != 16'h0) ? 16'hFFFF : off[15:0];
        csum_fin = (csum_new == 16'h0 && nz_new) ? 16'hFFFF : csum_new;
    end

    // Next-state decode, frame pass-through/error beat and status output mux
    always_comb begin
        state_next          = state;
        m_axis_frame_tdata  = '0;
        m_axis_frame_tkeep  = '0;
        m_axis_frame_tuser  = 1'b0;
        m_axis_frame_tlast  = 1'b0;
        m_axis_frame_tvalid = 1'b0;
        take                = 1'b0;
        start_write         = 1'b0;
        load_end            = 1'b0;
        load_trunc          = 1'b0;
        drop_inc            = 1'b0;
        frame_inc           = 1'b0;
        case (state)
            IDLE: begin
                if (s_axis_tvalid && mid_frame) begin
                    // tail of a frame cut by reset: swallow it silently
                    if (!s_axis_tlast) state_next = DISCARD;
                end else if (s_axis_tvalid) begin
                    if (m_axis_frame_tready && m_axis_status_tready && !hold_valid) begin
                        m_axis_frame_tdata  = s_axis_tdata;
                        m_axis_frame_tkeep  = s_axis_tkeep;
                        m_axis_frame_tuser  = s_axis_tuser[0];
                        m_axis_frame_tlast  = s_axis_tlast;
                        m_axis_frame_tvalid = 1'b1;
                        take                = 1'b1;
                        start_write         = !mode;
                        if (s_axis_tlast) begin
                            frame_inc = 1'b1;
                            load_end  = mode;
                        end else begin
                            state_next = PASS;
                        end
                    end else begin
                        drop_inc = 1'b1;
                        if (!s_axis_tlast) state_next = DISCARD;
                    end
                end
            end
            PASS: begin
                m_axis_frame_tdata  = s_axis_tdata;
                m_axis_frame_tkeep  = s_axis_tkeep;
                m_axis_frame_tuser  = s_axis_tuser[0];
                m_axis_frame_tlast  = s_axis_tlast;
                m_axis_frame_tvalid = s_axis_tvalid;
                if (s_axis_tvalid) begin
                    if (m_axis_frame_tready) begin
                        take = 1'b1;
                        if (s_axis_tlast) begin
                            state_next = IDLE;
                            frame_inc  = 1'b1;
                            load_end   = mode_q;
                        end
                    end else begin
                        state_next = TRUNC;
                        load_trunc = mode_q;
                    end
                end
            end
            TRUNC: begin
                m_axis_frame_tkeep[0] = 1'b1;
                m_axis_frame_tuser    = 1'b1;
                m_axis_frame_tlast    = 1'b1;
                m_axis_frame_tvalid   = 1'b1;
                if (m_axis_frame_tready) begin
                    drop_inc   = 1'b1;
                    state_next = (seen_last || (s_axis_tvalid && s_axis_tlast)) ? IDLE : DISCARD;
                end
            end
            DISCARD: begin
                if (s_axis_tvalid && s_axis_tlast) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        m_axis_status_tvalid = hold_valid || start_write;
        if (hold_valid)
            m_axis_status_tdata = hold_data;
        else if (start_write)
            m_axis_status_tdata = {32'h0, 4'h0, 1'b0, s_axis_tuser[0], 1'b0, s_axis_tuser[1]};
        else
            m_axis_status_tdata = '0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Source frame-boundary tracker; kept running through reset so a frame cut
    // by reset is recognised and discarded afterwards
    always_ff @(posedge clk) begin
        if (s_axis_tvalid) mid_frame <= !s_axis_tlast;
    end

    // Per-frame accumulators, latched mode and lost-tlast memory for TRUNC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            off       <= '0;
            csum      <= '0;
            csum_nz   <= 1'b0;
            mod_q     <= 1'b0;
            err_q     <= 1'b0;
            mode_q    <= 1'b0;
            seen_last <= 1'b0;
        end else begin
            if (take) begin
                off     <= off_new;
                csum    <= csum_new;
                csum_nz <= nz_new;
                mod_q   <= mod_new;
                err_q   <= err_new;
                if (first) mode_q <= mode;
            end
            if (state == PASS)
                seen_last <= s_axis_tvalid && s_axis_tlast;
            else if (state == TRUNC && s_axis_tvalid && s_axis_tlast)
                seen_last <= 1'b1;
        end
    end

    // Status holding register for end-of-frame and truncation status words
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (load_end) begin
            hold_valid <= 1'b1;
            hold_data  <= {csum_fin, len_new, 4'h0, cur_mode, err_new, 1'b0, mod_new};
        end else if (load_trunc) begin
            hold_valid <= 1'b1;
            hold_data  <= {16'h0, len_cur, 4'h0, mode_q, err_q, 1'b1, mod_q};
        end else if (hold_valid && m_axis_status_tready) begin
            hold_valid <= 1'b0;
        end
    end

`ifdef ETH_FRAME_LOOP_RX_STATS_EN
    // Drop and completion counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_count  <= '0;
            frame_count <= '0;
        end else begin
            if (drop_inc)  drop_count  <= drop_count + 32'd1;
            if (frame_inc) frame_count <= frame_count + 32'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = drop_inc ^ frame_inc;
    assign drop_count   = '0;
    assign frame_count  = '0;
`endif

endmodule

// File: tb/tb_eth_frame_loop_rx_wide.sv
// Scoreboard bench for eth_frame_loop_rx_wide (B=4, C_CSUM_START=14).
// Stimulus pushes expected frame beats and status words; a negedge monitor pops
// and compares on every accepted output beat.
module tb_eth_frame_loop_rx_wide;
    localparam int B = 4;
`ifdef ETH_FRAME_LOOP_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode = 1'b0;
    logic [31:0]   m_axis_frame_tdata;
    logic [B-1:0]  m_axis_frame_tkeep;
    logic          m_axis_frame_tuser, m_axis_frame_tlast, m_axis_frame_tvalid;
    logic          m_axis_frame_tready = 1'b1;
    logic [39:0]   m_axis_status_tdata;
    logic          m_axis_status_tvalid;
    logic          m_axis_status_tready = 1'b1;
    logic [31:0]   s_axis_tdata = '0;
    logic [B-1:0]  s_axis_tkeep = '0;
    logic [1:0]    s_axis_tuser = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic [31:0]   drop_count, frame_count;

    eth_frame_loop_rx_wide #(.C_AXIS_BYTES(B), .C_CSUM_START(14)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .m_axis_frame_tdata(m_axis_frame_tdata), .m_axis_frame_tkeep(m_axis_frame_tkeep),
        .m_axis_frame_tuser(m_axis_frame_tuser), .m_axis_frame_tlast(m_axis_frame_tlast),
        .m_axis_frame_tvalid(m_axis_frame_tvalid), .m_axis_frame_tready(m_axis_frame_tready),
        .m_axis_status_tdata(m_axis_status_tdata), .m_axis_status_tvalid(m_axis_status_tvalid),
        .m_axis_status_tready(m_axis_status_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .drop_count(drop_count), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int exp_drop = 0;
    int exp_frames = 0;
    logic [37:0] fq[$];
    logic [39:0] sq[$];
    logic [7:0]  fb [0:255];
    logic [37:0] fexp;
    logic [39:0] sexp;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every accepted frame beat and status word with the queues
    always @(negedge clk) begin
        if (m_axis_frame_tvalid && m_axis_frame_tready) begin
            if (fq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL frame_unexpected got=%h", {m_axis_frame_tdata, m_axis_frame_tkeep,
                         m_axis_frame_tuser, m_axis_frame_tlast});
            end else begin
                fexp = fq.pop_front();
                chk("frame_beat", 64'({m_axis_frame_tdata, m_axis_frame_tkeep,
                    m_axis_frame_tuser, m_axis_frame_tlast}), 64'(fexp));
            end
        end
        if (m_axis_status_tvalid && m_axis_status_tready) begin
            if (sq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL status_unexpected got=%h", m_axis_status_tdata);
            end else begin
                sexp = sq.pop_front();
                chk("status_word", 64'(m_axis_status_tdata), 64'(sexp));
            end
        end
    end

    task automatic fill_ramp();
        for (int i = 0; i < 256; i++) fb[i] = 8'(i);
    endtask

    task automatic idle_inputs();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tkeep  = '0;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;
        m_axis_frame_tready = 1'b1;
    endtask

    task automatic drive_beat(input int b, input int len, input logic [1:0] tu, input logic md);
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = ((b + 1) * B >= len);
        s_axis_tuser  = tu;
        mode          = md;
        for (int j = 0; j < B; j++) begin
            if (b * B + j < len) begin
                s_axis_tkeep[j]        = 1'b1;
                s_axis_tdata[8*j +: 8] = fb[b*B + j];
            end else begin
                s_axis_tkeep[j]        = 1'b0;
                s_axis_tdata[8*j +: 8] = 8'h00;
            end
        end
    endtask

    function automatic logic [37:0] cur_beat();
        return {s_axis_tdata, s_axis_tkeep, s_axis_tuser[0], s_axis_tlast};
    endfunction

    // One frame; stall = 1-based beat where frame_tready drops (0 = none)
    task automatic send_frame(input int len, input logic md, input logic [1:0] tu,
                              input int stall, input bit drop_it, input logic [15:0] exp_csum);
        int nb;
        nb = (len + B - 1) / B;
        if (drop_it) begin
            exp_drop++;
        end else begin
            if (!md)
                sq.push_back({32'h0, 4'h0, 1'b0, tu[0], 1'b0, tu[1]});
            else if (stall != 0)
                sq.push_back({16'h0, 16'((stall - 1) * B), 4'h0, 1'b1, tu[0], 1'b1, tu[1]});
            else
                sq.push_back({exp_csum, 16'(len), 4'h0, 1'b1, tu[0], 1'b0, tu[1]});
            if (stall != 0) exp_drop++;
            else            exp_frames++;
        end
        for (int b = 0; b < nb; b++) begin
            drive_beat(b, len, (b == 0) ? tu : 2'b00, md);
            m_axis_frame_tready = !(stall != 0 && b + 1 == stall);
            if (!drop_it) begin
                if (stall == 0 || b + 1 < stall)
                    fq.push_back(cur_beat());
                else if (b + 1 == stall)
                    fq.push_back({32'h0, 4'b0001, 1'b1, 1'b1});
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_drop_count"}, 64'(drop_count), STATS ? 64'(exp_drop) : 64'd0);
        chk({tag, "_frame_count"}, 64'(frame_count), STATS ? 64'(exp_frames) : 64'd0);
    endtask

    initial begin
        fill_ramp();
        idle_inputs();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        // reset state
        chk("rst_frame_tvalid", 64'(m_axis_frame_tvalid), 64'd0);
        chk("rst_frame_tdata", 64'(m_axis_frame_tdata), 64'd0);
        chk("rst_frame_tkeep", 64'(m_axis_frame_tkeep), 64'd0);
        chk("rst_frame_tuser_tlast", 64'({m_axis_frame_tuser, m_axis_frame_tlast}), 64'd0);
        chk("rst_status_tvalid", 64'(m_axis_status_tvalid), 64'd0);
        chk_counters("rst");

        // 64B ramp, mode 1: csum over bytes 14..63 = 0xB9D2
        send_frame(64, 1'b1, 2'b00, 0, 1'b0, 16'hB9D2);
        // 61B ramp: last beat keep 0001, byte 60 padded low, csum 0x7B56
        send_frame(61, 1'b1, 2'b00, 0, 1'b0, 16'h7B56);
        // single-beat frame, mode 1, rx error: len 4, nothing summed, flags 0x0C
        send_frame(4, 1'b1, 2'b01, 0, 1'b0, 16'h0000);
        chk_counters("after_good");

        // sink stall at beat 5 of 16: status {0,16,0x0A} and an error beat
        send_frame(64, 1'b1, 2'b00, 5, 1'b0, 16'h0000);
        repeat (2) tick();
        chk_counters("after_trunc");

        // status sink busy at frame start: whole frame dropped
        m_axis_status_tready = 1'b0;
        send_frame(16, 1'b1, 2'b00, 0, 1'b1, 16'h0000);
        m_axis_status_tready = 1'b1;
        tick();
        chk_counters("after_drop");
        send_frame(64, 1'b1, 2'b00, 0, 1'b0, 16'hB9D2);

        // mode 0 with frame-modified on first beat: status {0,0,0x01}
        send_frame(8, 1'b0, 2'b10, 0, 1'b0, 16'h0000);
        repeat (2) tick();
        chk_counters("after_mode0");

        // reset in the middle of a mode-1 frame
        for (int b = 0; b < 5; b++) begin
            drive_beat(b, 64, 2'b00, 1'b1);
            fq.push_back(cur_beat());
            tick();
        end
        idle_inputs();
        rst_n = 1'b0;
        tick();
        drive_beat(5, 64, 2'b00, 1'b1);
        tick();
        rst_n = 1'b1;
        exp_drop = 0;
        exp_frames = 0;
        for (int b = 6; b < 16; b++) begin
            drive_beat(b, 64, 2'b00, 1'b1);
            tick();
        end
        idle_inputs();
        tick();
        chk_counters("after_reset");
        chk("post_reset_status_tvalid", 64'(m_axis_status_tvalid), 64'd0);
        send_frame(8, 1'b0, 2'b01, 0, 1'b0, 16'h0000);
        repeat (4) tick();
        chk_counters("final");

        chk("frame_queue_left", 64'(fq.size()), 64'd0);
        chk("status_queue_left", 64'(sq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
